// File: rtl/proc_packet_arbiter_if.sv
// Processor packet arbiter bus interface.
// Bundles the host-side requester handshake, the read-response path and the
// Garnet proc_packet_wr_*/rd_* signals. When PROC_ARB_BURST_LOCK_EN is defined
// the bundle also carries req_lock.
interface proc_packet_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_is_wr;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ*STRB_WIDTH-1:0] req_strb;
`ifdef PROC_ARB_BURST_LOCK_EN
  logic [NUM_REQ-1:0]            req_lock;
`endif
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          proc_wr_en;
  logic [STRB_WIDTH-1:0]         proc_wr_strb;
  logic [ADDR_WIDTH-1:0]         proc_wr_addr;
  logic [DATA_WIDTH-1:0]         proc_wr_data;
  logic                          proc_rd_en;
  logic [ADDR_WIDTH-1:0]         proc_rd_addr;
  logic [DATA_WIDTH-1:0]         proc_rd_data;
  logic                          proc_rd_data_valid;

  // Arbiter side
  modport slave (
`ifdef PROC_ARB_BURST_LOCK_EN
    input  req_lock,
`endif
    input  req_valid, req_is_wr, req_addr, req_wdata, req_strb,
    input  proc_rd_data, proc_rd_data_valid,
    output req_ready, rsp_valid, rsp_data,
    output proc_wr_en, proc_wr_strb, proc_wr_addr, proc_wr_data,
    output proc_rd_en, proc_rd_addr
  );

  // Host / Garnet side
  modport master (
`ifdef PROC_ARB_BURST_LOCK_EN
    output req_lock,
`endif
    output req_valid, req_is_wr, req_addr, req_wdata, req_strb,
    output proc_rd_data, proc_rd_data_valid,
    input  req_ready, rsp_valid, rsp_data,
    input  proc_wr_en, proc_wr_strb, proc_wr_addr, proc_wr_data,
    input  proc_rd_en, proc_rd_addr
  );
endinterface

// File: rtl/proc_packet_arbiter.sv
// Round-robin arbiter sharing the Garnet processor packet port among NUM_REQ
// requesters. One beat per grant, registered issue, read responses routed back
// to their issuer through an in-order ID queue of depth MAX_RD_OUT.
// Optional feature macro: PROC_ARB_BURST_LOCK_EN (adds req_lock burst locking).
module proc_packet_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = 8,
  parameter int MAX_RD_OUT = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  proc_packet_arbiter_if.slave        bus,
  output logic [$clog2(MAX_RD_OUT):0] rd_outstanding,
  output logic                        err_unexpected
);
  localparam int          IDW = $clog2(NUM_REQ);
  localparam int          PW  = $clog2(MAX_RD_OUT);
  localparam int          CW  = PW + 1;
  localparam int unsigned NR  = NUM_REQ;

  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     gnt_id;
  logic               gnt_found;
  logic [NUM_REQ-1:0] eligible;
  logic               q_full;
  logic               q_empty;
  logic               push;
  logic               pop;
  logic [IDW-1:0]     id_q [MAX_RD_OUT];
  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic [IDW-1:0]     head;

`ifdef PROC_ARB_BURST_LOCK_EN
  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;
  lock_state_t    lock_state;
  logic [IDW-1:0] lock_id;
`endif

  // Eligibility, round-robin grant and read-response routing
  always_comb begin
    q_full    = (rd_outstanding == CW'(MAX_RD_OUT));
    q_empty   = (rd_outstanding == '0);
    eligible  = bus.req_valid & (bus.req_is_wr | {NUM_REQ{~q_full}});
    gnt_found = 1'b0;
    gnt_id    = ptr;
`ifdef PROC_ARB_BURST_LOCK_EN
    if (lock_state == LOCKED && bus.req_lock[lock_id]) begin
      gnt_found = eligible[lock_id];
      gnt_id    = lock_id;
    end else begin
`else
    begin
`endif
      for (int unsigned k = 1; k <= NR; k++) begin
        if (!gnt_found && eligible[IDW'((32'(ptr) + k) % NR)]) begin
          gnt_found = 1'b1;
          gnt_id    = IDW'((32'(ptr) + k) % NR);
        end
      end
    end
    bus.req_ready = '0;
    if (gnt_found && reset_n) bus.req_ready[gnt_id] = 1'b1;
    push = gnt_found & ~bus.req_is_wr[gnt_id];
    head = id_q[rptr];
    pop  = bus.proc_rd_data_valid & ~q_empty;
    bus.rsp_valid = '0;
    if (pop) bus.rsp_valid[head] = 1'b1;
    bus.rsp_data = pop ? bus.proc_rd_data : '0;
  end

  // Grant pointer, ID queue and sticky error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr            <= IDW'(NR - 1);
      wptr           <= '0;
      rptr           <= '0;
      rd_outstanding <= '0;
      err_unexpected <= 1'b0;
      for (int unsigned i = 0; i < MAX_RD_OUT; i++) id_q[i] <= '0;
    end else begin
      if (gnt_found) ptr <= gnt_id;
      if (push) begin
        id_q[wptr] <= gnt_id;
        wptr       <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      rd_outstanding <= rd_outstanding + CW'(push) - CW'(pop);
      if (bus.proc_rd_data_valid && q_empty) err_unexpected <= 1'b1;
    end
  end

  // Registered one-cycle issue of the accepted beat to the proc ports
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.proc_wr_en   <= 1'b0;
      bus.proc_rd_en   <= 1'b0;
      bus.proc_wr_addr <= '0;
      bus.proc_wr_data <= '0;
      bus.proc_wr_strb <= '0;
      bus.proc_rd_addr <= '0;
    end else begin
      bus.proc_wr_en <= gnt_found & bus.req_is_wr[gnt_id];
      bus.proc_rd_en <= push;
      if (gnt_found && bus.req_is_wr[gnt_id]) begin
        bus.proc_wr_addr <= bus.req_addr[gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
        bus.proc_wr_data <= bus.req_wdata[gnt_id*DATA_WIDTH +: DATA_WIDTH];
        bus.proc_wr_strb <= bus.req_strb[gnt_id*STRB_WIDTH +: STRB_WIDTH];
      end
      if (push) bus.proc_rd_addr <= bus.req_addr[gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

`ifdef PROC_ARB_BURST_LOCK_EN
  // Burst lock: held from a locked accept until req_lock of the holder drops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_state <= UNLOCKED;
      lock_id    <= '0;
    end else begin
      if (gnt_found && bus.req_lock[gnt_id]) begin
        lock_state <= LOCKED;
        lock_id    <= gnt_id;
      end else if (lock_state == LOCKED && !bus.req_lock[lock_id]) begin
        lock_state <= UNLOCKED;
      end
    end
  end
`endif
endmodule

// File: tb/tb_proc_packet_arbiter.sv
// Scoreboard bench for proc_packet_arbiter: a randomized driver runs a
// queue-based reference model and posts expectations; a negedge monitor pops
// and compares them against what the arbiter presents.
module tb_proc_packet_arbiter;
  localparam int NR = 2;
  localparam int AW = 19;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int MO = 4;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [$clog2(MO):0] rd_outstanding;
  logic                err_unexpected;

  proc_packet_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) bus ();

  proc_packet_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .STRB_WIDTH(SW), .MAX_RD_OUT(MO)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .rd_outstanding(rd_outstanding), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  typedef struct { logic [NR-1:0] ready; int occ; logic err; } cyc_t;
  typedef struct { logic [NR-1:0] v; logic [DW-1:0] d; int stamp; } rsp_t;
  typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; logic [SW-1:0] strb; int stamp; } iss_t;

  cyc_t cq[$];
  rsp_t rq[$];
  iss_t iq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit sb_on = 0;

  // reference model state
  int unsigned m_ptr;
  int          m_q[$];
  logic        m_err;

  logic [AW-1:0] last_wr_addr, last_rd_addr;
  logic [DW-1:0] last_wr_data;
  logic [SW-1:0] last_wr_strb;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // One randomized cycle: drive inputs, derive expectations from the model rules
  task automatic drive_cycle(input int vprob, input int rdbias, input int retprob);
    logic [NR-1:0] v, w, exp_ready;
    logic [DW-1:0] rdat;
    bit ret, full;
    int g, id;
    cyc_t c;
    rsp_t r;
    iss_t s;
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      v[i] = ($urandom_range(0, 99) < vprob);
      w[i] = ($urandom_range(0, 99) >= rdbias);
      bus.req_addr[i*AW +: AW]  = AW'($urandom);
      bus.req_wdata[i*DW +: DW] = {$urandom, $urandom};
      bus.req_strb[i*SW +: SW]  = SW'($urandom);
    end
    ret  = (m_q.size() > 0) && ($urandom_range(0, 99) < retprob);
    rdat = {$urandom, $urandom};
    bus.req_valid          = v;
    bus.req_is_wr          = w;
    bus.proc_rd_data       = rdat;
    bus.proc_rd_data_valid = ret;

    full = (m_q.size() == MO);
    g = -1;
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (int'(m_ptr) + k) % NR;
      if (g < 0 && v[idx] && (w[idx] || !full)) g = idx;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    c.ready = exp_ready; c.occ = m_q.size(); c.err = m_err;
    cq.push_back(c);
    if (ret) begin
      id = m_q.pop_front();
      r.v = '0; r.v[id] = 1'b1; r.d = rdat; r.stamp = cyc;
      rq.push_back(r);
    end
    if (g >= 0) begin
      s.wr = w[g]; s.addr = bus.req_addr[g*AW +: AW];
      s.data = bus.req_wdata[g*DW +: DW]; s.strb = bus.req_strb[g*SW +: SW];
      s.stamp = cyc + 1;
      iq.push_back(s);
      m_ptr = g;
      if (!w[g]) m_q.push_back(g);
    end
  endtask

  // Monitor: compares per-cycle state, responses and issued beats
  always @(negedge clk) begin
    if (sb_on) begin
      if (cq.size() > 0) begin
        cyc_t c;
        c = cq.pop_front();
        chk("req_ready", 64'(bus.req_ready), 64'(c.ready));
        chk("rd_outstanding", 64'(rd_outstanding), 64'(c.occ));
        chk("err_unexpected", 64'(err_unexpected), 64'(c.err));
      end
      if (bus.rsp_valid != '0) begin
        if (rq.size() == 0) chk("rsp_spurious", 64'(bus.rsp_valid), 64'(0));
        else begin
          rsp_t r;
          r = rq.pop_front();
          chk("rsp_valid", 64'(bus.rsp_valid), 64'(r.v));
          chk("rsp_data", bus.rsp_data, r.d);
          chk("rsp_cycle", 64'(cyc), 64'(r.stamp));
        end
      end else if (rq.size() > 0 && rq[0].stamp <= cyc) begin
        rsp_t r;
        r = rq.pop_front();
        chk("rsp_missing", 64'(bus.rsp_valid), 64'(r.v));
      end
      if (bus.proc_wr_en || bus.proc_rd_en) begin
        if (iq.size() == 0) chk("issue_spurious", 64'({bus.proc_wr_en, bus.proc_rd_en}), 64'(0));
        else begin
          iss_t s;
          s = iq.pop_front();
          chk("issue_en", 64'({bus.proc_wr_en, bus.proc_rd_en}), 64'({s.wr, ~s.wr}));
          chk("issue_cycle", 64'(cyc), 64'(s.stamp));
          if (s.wr) begin
            chk("proc_wr_addr", 64'(bus.proc_wr_addr), 64'(s.addr));
            chk("proc_wr_data", bus.proc_wr_data, s.data);
            chk("proc_wr_strb", 64'(bus.proc_wr_strb), 64'(s.strb));
            last_wr_addr = s.addr; last_wr_data = s.data; last_wr_strb = s.strb;
          end else begin
            chk("proc_rd_addr", 64'(bus.proc_rd_addr), 64'(s.addr));
            last_rd_addr = s.addr;
          end
        end
      end else begin
        if (iq.size() > 0 && iq[0].stamp <= cyc) begin
          iss_t s;
          s = iq.pop_front();
          chk("issue_missing", 64'({bus.proc_wr_en, bus.proc_rd_en}), 64'({s.wr, ~s.wr}));
        end
        chk("hold_wr", {bus.proc_wr_addr, bus.proc_wr_strb} ^ bus.proc_wr_data,
            {last_wr_addr, last_wr_strb} ^ last_wr_data);
        chk("hold_rd_addr", 64'(bus.proc_rd_addr), 64'(last_rd_addr));
      end
    end
  end

  initial begin
    m_ptr = NR - 1; m_err = 1'b0;
    last_wr_addr = '0; last_wr_data = '0; last_wr_strb = '0; last_rd_addr = '0;
    bus.req_valid = '1; bus.req_is_wr = '1;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_strb = '0;
    bus.proc_rd_data = '0; bus.proc_rd_data_valid = 1'b0;
`ifdef PROC_ARB_BURST_LOCK_EN
    bus.req_lock = '0;
`endif
    // reset state with both requesters asking
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 64'(bus.req_ready), 64'(0));
    chk("reset_wr_en", 64'(bus.proc_wr_en), 64'(0));
    chk("reset_rd_en", 64'(bus.proc_rd_en), 64'(0));
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("reset_outstanding", 64'(rd_outstanding), 64'(0));
    bus.req_valid = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;

    sb_on = 1;
    repeat (300) drive_cycle(70, 50, 40);   // mixed traffic
    repeat (200) drive_cycle(85, 85, 10);   // read-heavy, queue fills
    repeat (300) drive_cycle(60, 20, 50);   // write-heavy
    for (int n = 0; n < 20 && m_q.size() > 0; n++) drive_cycle(0, 0, 100);
    chk("drain_done", 64'(m_q.size()), 64'(0));
    @(posedge clk); #1;
    bus.req_valid = '0; bus.proc_rd_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    sb_on = 0;

    // spurious return while the queue is empty
    @(posedge clk); #1;
    bus.proc_rd_data = 64'hDEAD_BEEF_0000_1234;
    bus.proc_rd_data_valid = 1'b1;
    @(negedge clk);
    chk("spurious_no_rsp", 64'(bus.rsp_valid), 64'(0));
    chk("spurious_err_pre", 64'(err_unexpected), 64'(0));
    @(posedge clk); #1;
    bus.proc_rd_data_valid = 1'b0;
    @(negedge clk);
    chk("spurious_err_set", 64'(err_unexpected), 64'(1));
    repeat (5) @(negedge clk);
    chk("spurious_err_sticky", 64'(err_unexpected), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("reset_clears_err", 64'(err_unexpected), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
